// File: rtl/mem_bus_pkg.sv
// Shared constants for the CPU byte bus memory responder: I/O window decode
// addresses and bus widths.
package mem_bus_pkg;
  localparam int BYTE_W = 8;
  localparam int ADDR_W = 32;
  localparam logic [1:0]        IO_SEL       = 2'b11;
  localparam logic [ADDR_W-1:0] IO_UART_ADDR = 32'h0003_0000;
  localparam logic [ADDR_W-1:0] IO_CLK_ADDR  = 32'h0003_0004;
endpackage

// File: rtl/byte_fifo.sv
// Circular FIFO with count register; push while full is taken only when a pop
// frees the slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/mem_bus_responder.sv
// Memory side of the CPU byte bus: program/data RAM plus the UART and
// cycle-counter/stop I/O ports, with rdy_out freezing the CPU on I/O stalls.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic [BYTE_W-1:0] mem_dout,
  input  logic              mem_wr,
  output logic [BYTE_W-1:0] mem_din,
  output logic              rdy_out,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              halted
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [BYTE_W-1:0] ram_q [0:(1<<RAM_AW)-1];
  logic [BYTE_W-1:0] din_q, rd_d, rx_head;
  logic [CNT_W-1:0]  cnt_q, snap_q;
  logic              halted_q;
  logic [17:0]       a18;
  logic              io_sel, is_uart, is_clk, is_stop;
  logic              uart_rd, uart_wr, stop_wr;
  logic              rx_full, rx_empty, tx_full, tx_empty, rx_pop, tx_push;
  logic [CW-1:0]     rx_cnt, tx_cnt;
  logic              unused_bits;

  assign a18     = mem_a[17:0];
  assign io_sel  = (a18[17:16] == IO_SEL);
  assign is_uart = (a18 == IO_UART_ADDR[17:0]);
  assign is_clk  = (a18[17:2] == IO_CLK_ADDR[17:2]);
  assign is_stop = (a18 == IO_CLK_ADDR[17:0]);
  assign uart_rd = is_uart && !mem_wr;
  assign uart_wr = is_uart && mem_wr && (mem_dout != '0);
  assign stop_wr = is_stop && mem_wr;

  // Stall terms are combinational on the live bus so the CPU freezes the same cycle.
  assign rdy_out = !(halted_q || (uart_rd && rx_empty) || ((uart_wr || stop_wr) && tx_full));
  assign rx_pop  = rdy_out && uart_rd;
  assign tx_push = rdy_out && (uart_wr || stop_wr);

  assign mem_din     = din_q;
  assign halted      = halted_q;
  assign rx_ready    = !rx_full;
  assign tx_valid    = !tx_empty;
  assign unused_bits = ^{mem_a[ADDR_W-1:18], rx_cnt, tx_cnt};

  byte_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_rx (
    .clk_in (clk_in), .rst_in (rst_in),
    .push_i (rx_valid && !rx_full), .din_i (rx_data), .pop_i (rx_pop),
    .dout_o (rx_head), .full_o (rx_full), .empty_o (rx_empty), .count_o (rx_cnt)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_tx (
    .clk_in (clk_in), .rst_in (rst_in),
    .push_i (tx_push), .din_i (stop_wr ? '0 : mem_dout), .pop_i (tx_ready),
    .dout_o (tx_data), .full_o (tx_full), .empty_o (tx_empty), .count_o (tx_cnt)
  );

  always_comb begin
    rd_d = '0;
    if (!io_sel)      rd_d = ram_q[mem_a[RAM_AW-1:0]];
    else if (is_uart) rd_d = rx_head;
    else if (is_clk) begin
      // Byte 0 reads the live counter; upper bytes come from the snapshot it took.
      case (a18[1:0])
        2'd0:    rd_d = cnt_q[7:0];
        2'd1:    rd_d = snap_q[15:8];
        2'd2:    rd_d = snap_q[23:16];
        default: rd_d = snap_q[31:24];
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      din_q    <= '0;
      cnt_q    <= '0;
      snap_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (rdy_out && !mem_wr) din_q <= rd_d;
      if (rdy_out && !mem_wr && is_clk && a18[1:0] == 2'd0) snap_q <= cnt_q;
      if (rdy_out && stop_wr) halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_out && mem_wr && !io_sel && !rst_in) ram_q[mem_a[RAM_AW-1:0]] <= mem_dout;
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized + directed bench for mem_bus_responder against a queue-based bus model.
module tb_mem_bus_responder;
  localparam int D = 8;
  localparam logic [31:0] IDLE_A = 32'h0003_0010;

  logic        clk_in = 1'b0, rst_in = 1'b0;
  logic [31:0] mem_a = IDLE_A;
  logic [7:0]  mem_dout = '0, mem_din, rx_data = '0, tx_data;
  logic        mem_wr = 1'b0, rdy_out, rx_valid = 1'b0, rx_ready, tx_valid, tx_ready = 1'b0, halted;

  always #5 clk_in = ~clk_in;

  mem_bus_responder dut (
    .clk_in (clk_in), .rst_in (rst_in), .mem_a (mem_a), .mem_dout (mem_dout),
    .mem_wr (mem_wr), .mem_din (mem_din), .rdy_out (rdy_out),
    .rx_data (rx_data), .rx_valid (rx_valid), .rx_ready (rx_ready),
    .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready), .halted (halted)
  );

  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  ram_m [0:131071];
  logic [7:0]  rxq[$], txq[$], tx_log[$];
  logic [31:0] cnt_m = 0, snap_m = 0;
  logic [7:0]  din_m = 0;
  bit          halt_m = 0;
  logic [31:0] ram_set [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_rdy();
    logic [17:0] a = mem_a[17:0];
    bit uart = (a == 18'h30000);
    bit stop = (a == 18'h30004);
    if (halt_m) return 1'b0;
    if (uart && !mem_wr && rxq.size() == 0) return 1'b0;
    if (mem_wr && ((uart && mem_dout != 0) || stop) && txq.size() == D) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [17:0] a;
    logic [31:0] sh;
    logic [7:0]  v, txv;
    bit          acc, io, txpush, rxpush, txpop;
    int          k;
    if (rst_in) begin
      rxq.delete(); txq.delete();
      cnt_m = 0; snap_m = 0; din_m = 0; halt_m = 0;
      return;
    end
    a = mem_a[17:0];
    acc = exp_rdy();
    io = (a >= 18'h30000);
    txpop = txq.size() > 0 && tx_ready;
    rxpush = rx_valid && rxq.size() < D;
    txpush = 0; txv = 0; v = 0;
    if (acc && mem_wr) begin
      if (!io) ram_m[a[16:0]] = mem_dout;
      else if (a == 18'h30000 && mem_dout != 0) begin txpush = 1; txv = mem_dout; end
      else if (a == 18'h30004) begin txpush = 1; halt_m = 1; end
    end else if (acc) begin
      if (!io) v = ram_m[a[16:0]];
      else if (a == 18'h30000) v = rxq.pop_front();
      else if (a >= 18'h30004 && a <= 18'h30007) begin
        k = int'(a - 18'h30004);
        if (k == 0) begin v = cnt_m[7:0]; snap_m = cnt_m; end
        else begin sh = snap_m >> (8 * k); v = sh[7:0]; end
      end
      din_m = v;
    end
    if (txpop) void'(txq.pop_front());
    if (txpush) txq.push_back(txv);
    if (rxpush) rxq.push_back(rx_data);
    cnt_m++;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one clock.
  task automatic step();
    #1;
    chk("rdy", 32'(rdy_out), 32'(exp_rdy()));
    chk("din", 32'(mem_din), 32'(din_m));
    chk("rx_ready", 32'(rx_ready), 32'(rxq.size() < D));
    chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
    if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
    chk("halted", 32'(halted), 32'(halt_m));
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  task automatic xfer(input logic [31:0] a, input bit w, input logic [7:0] d);
    bit done = 0;
    mem_a = a; mem_wr = w; mem_dout = d;
    for (int i = 0; i < 40 && !done; i++) begin
      done = exp_rdy();
      step();
    end
    chk("xfer_done", 32'(done), 32'd1);
    mem_a = IDLE_A; mem_wr = 0; mem_dout = 0;
  endtask

  task automatic do_reset();
    rst_in = 1; mem_a = IDLE_A; mem_wr = 0; rx_valid = 0; tx_ready = 0;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    rst_in = 0;
    #1;
    chk("rst_din", 32'(mem_din), 32'h0);
    chk("rst_rdy", 32'(rdy_out), 32'h1);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
    chk("rst_halted", 32'(halted), 32'h0);
  endtask

  initial begin
    logic [7:0]  b [4];
    logic [31:0] exp_snap;
    logic [17:0] a;
    bit          hold;

    do_reset();
    ram_set[0] = 32'h10;
    for (int i = 1; i < 16; i++) ram_set[i] = (i * 32'h1357 + 32'h5) & 32'h1FFFF;
    for (int i = 0; i < 16; i++) xfer(ram_set[i], 1, 8'($urandom()));

    // RAM write then read-back
    xfer(32'h10, 1, 8'hA5);
    xfer(32'h10, 0, 8'h00);
    chk("ram_rdback", 32'(mem_din), 32'hA5);

    // UART read stalls on empty rx until a byte arrives
    mem_a = 32'h30000; mem_wr = 0;
    repeat (5) begin #1; chk("rx_stall", 32'(rdy_out), 32'h0); step(); end
    rx_valid = 1; rx_data = 8'h41; step();
    rx_valid = 0;
    #1; chk("rx_release", 32'(rdy_out), 32'h1);
    step();
    chk("rx_byte", 32'(mem_din), 32'h41);
    mem_a = IDLE_A;

    // UART writes, zero byte dropped
    tx_log.delete(); tx_ready = 1;
    xfer(32'h30000, 1, 8'h48); xfer(32'h30000, 1, 8'h00); xfer(32'h30000, 1, 8'h69);
    repeat (4) step();
    chk("tx_cnt", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() == 2) begin
      chk("tx_b0", 32'(tx_log[0]), 32'h48);
      chk("tx_b1", 32'(tx_log[1]), 32'h69);
    end

    // tx full stall released by a single tx_ready pulse
    tx_ready = 0; tx_log.delete();
    for (int i = 1; i <= 8; i++) xfer(32'h30000, 1, 8'(i));
    mem_a = 32'h30000; mem_wr = 1; mem_dout = 8'h09;
    #1; chk("tx_full_stall", 32'(rdy_out), 32'h0);
    step();
    tx_ready = 1; step();
    tx_ready = 0;
    #1; chk("tx_full_release", 32'(rdy_out), 32'h1);
    step();
    mem_a = IDLE_A; mem_wr = 0; tx_ready = 1;
    repeat (12) step();
    chk("tx_full_cnt", 32'(tx_log.size()), 32'd9);
    for (int i = 0; i < tx_log.size() && i < 9; i++) chk("tx_full_seq", 32'(tx_log[i]), 32'(i + 1));

    // coherent 4-byte counter read across a low-byte carry
    for (int i = 0; i < 300 && cnt_m[7:0] != 8'hFF; i++) step();
    exp_snap = cnt_m;
    for (int k = 0; k < 4; k++) begin
      xfer(32'h30004 + 32'(k), 0, 8'h00);
      b[k] = mem_din;
    end
    chk("clk_snap", {b[3], b[2], b[1], b[0]}, exp_snap);

    // randomized traffic with the CPU holding the bus while stalled
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        mem_wr = 0; mem_dout = 8'($urandom());
        case ($urandom_range(0, 9))
          0, 1, 2: a = ram_set[$urandom_range(0, 15)][17:0];
          3:       a = ram_set[$urandom_range(0, 15)][17:0] | 18'h20000;
          4, 5:    begin a = ram_set[$urandom_range(0, 15)][17:0]; mem_wr = 1; end
          6:       a = 18'h30000;
          7:       begin
                     a = 18'h30000; mem_wr = 1;
                     if ($urandom_range(0, 3) == 0) mem_dout = 8'h00;
                   end
          8:       a = 18'h30004 + 18'($urandom_range(0, 3));
          default: begin
                     a = 18'h30008 + 18'($urandom_range(0, 32'hFFF7));
                     mem_wr = 1'($urandom_range(0, 1));
                   end
        endcase
        mem_a = {14'($urandom()), a};
      end
      rx_valid = 1'($urandom_range(0, 1));
      rx_data = 8'($urandom());
      tx_ready = ($urandom_range(0, 2) != 0);
      hold = !exp_rdy();
      step();
    end
    mem_a = IDLE_A; mem_wr = 0; rx_valid = 0; tx_ready = 1;
    repeat (12) step();

    // stop write: emits 0x00, halts and holds rdy low until reset
    tx_log.delete();
    xfer(32'h30004, 1, 8'h77);
    chk("halt_set", 32'(halted), 32'h1);
    mem_a = 32'h30000;
    repeat (4) begin #1; chk("halt_rdy", 32'(rdy_out), 32'h0); step(); end
    chk("stop_cnt", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("stop_byte", 32'(tx_log[0]), 32'h00);
    do_reset();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
